// File: rtl/sos_band_scheduler.sv
// Time-multiplexes one shared biquad engine across NUM_BANDS cascades of NUM_SECTIONS sections.
// Optional engine-response watchdog enabled by defining SOS_SCHED_TIMEOUT_EN.
module sos_band_scheduler #(
  parameter int WORD_SIZE    = 16,
  parameter int ACCUM_SIZE   = 32,
  parameter int NUM_BANDS    = 4,
  parameter int NUM_SECTIONS = 4,
  parameter int OUT_SHIFT    = 0,
  parameter int TIMEOUT      = 64
) (
  input  logic                         inClock,
  input  logic                         rst,
  input  logic signed [WORD_SIZE-1:0]  inData,
  input  logic                         inValid,
  output logic                         inReady,
  output logic                         secStart,
  output logic [3:0]                   secBand,
  output logic [3:0]                   secSection,
  output logic signed [ACCUM_SIZE-1:0] secData,
  input  logic                         secDone,
  input  logic signed [ACCUM_SIZE-1:0] secResult,
  output logic                         outValid,
  output logic [3:0]                   outBand,
  output logic signed [WORD_SIZE-1:0]  outData,
  output logic                         overrun,
  input  logic                         clrOverrun,
  output logic                         error
);

  // state | meaning
  // IDLE  | ready for a sample
  // ISSUE | secStart pulse for current band/section
  // WAIT  | waiting for engine result (or watchdog)
  // EMIT  | outValid with saturated band result
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

  localparam logic signed [ACCUM_SIZE-1:0] SAT_MAX =
    {{(ACCUM_SIZE-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [ACCUM_SIZE-1:0] SAT_MIN = ~SAT_MAX;

  state_t state_q, state_d;
  logic [3:0] band_q, sec_q, sec_band_q, sec_section_q, out_band_q;
  logic signed [WORD_SIZE-1:0]  sample_q, out_data_q, sat_data;
  logic signed [ACCUM_SIZE-1:0] acc_q, sec_data_q, shifted, in_ext, sample_ext;
  logic last_sec, last_band, timed_out, pass_done, overrun_q;

  assign in_ext     = {{(ACCUM_SIZE-WORD_SIZE){inData[WORD_SIZE-1]}}, inData};
  assign sample_ext = {{(ACCUM_SIZE-WORD_SIZE){sample_q[WORD_SIZE-1]}}, sample_q};
  assign last_sec   = (sec_q == 4'(NUM_SECTIONS-1));
  assign last_band  = (band_q == 4'(NUM_BANDS-1));
  assign pass_done  = secDone || timed_out;
  assign shifted    = acc_q >>> OUT_SHIFT;

  always_comb begin
    sat_data = shifted[WORD_SIZE-1:0];
    if (shifted > SAT_MAX)      sat_data = SAT_MAX[WORD_SIZE-1:0];
    else if (shifted < SAT_MIN) sat_data = SAT_MIN[WORD_SIZE-1:0];
  end

  always_ff @(posedge inClock or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    inReady  = 1'b0;
    secStart = 1'b0;
    outValid = 1'b0;
    case (state_q)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) state_d = ISSUE;
      end
      ISSUE: begin
        secStart = 1'b1;
        state_d  = WAIT;
      end
      WAIT: if (pass_done) state_d = last_sec ? EMIT : ISSUE;
      EMIT: begin
        outValid = 1'b1;
        state_d  = last_band ? IDLE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine-side and result-side fields are live during their strobe and held afterwards.
  assign secBand    = (state_q == ISSUE) ? band_q : sec_band_q;
  assign secSection = (state_q == ISSUE) ? sec_q  : sec_section_q;
  assign secData    = (state_q == ISSUE) ? acc_q  : sec_data_q;
  assign outBand    = (state_q == EMIT)  ? band_q : out_band_q;
  assign outData    = (state_q == EMIT)  ? sat_data : out_data_q;
  assign overrun    = overrun_q;

  always_ff @(posedge inClock or negedge rst) begin
    if (!rst) begin
      band_q        <= '0;
      sec_q         <= '0;
      sample_q      <= '0;
      acc_q         <= '0;
      sec_band_q    <= '0;
      sec_section_q <= '0;
      sec_data_q    <= '0;
      out_band_q    <= '0;
      out_data_q    <= '0;
      overrun_q     <= 1'b0;
    end else begin
      if (inValid && state_q != IDLE) overrun_q <= 1'b1;
      else if (clrOverrun)            overrun_q <= 1'b0;
      case (state_q)
        IDLE: if (inValid) begin
          sample_q <= inData;
          acc_q    <= in_ext;
          band_q   <= '0;
          sec_q    <= '0;
        end
        ISSUE: begin
          sec_band_q    <= band_q;
          sec_section_q <= sec_q;
          sec_data_q    <= acc_q;
        end
        WAIT: if (pass_done) begin
          acc_q <= secDone ? secResult : '0;
          if (!last_sec) sec_q <= sec_q + 4'd1;
        end
        EMIT: begin
          out_band_q <= band_q;
          out_data_q <= sat_data;
          if (!last_band) begin
            band_q <= band_q + 4'd1;
            sec_q  <= '0;
            acc_q  <= sample_ext;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SOS_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] timer_q;
  logic          error_q;

  assign timed_out = (state_q == WAIT) && !secDone && (timer_q == '0);
  assign error     = error_q;

  always_ff @(posedge inClock or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (state_q == ISSUE)
        timer_q <= TW'(TIMEOUT-1);
      else if (state_q == WAIT && !secDone && timer_q != '0)
        timer_q <= timer_q - TW'(1);
      if (timed_out) error_q <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_sos_band_scheduler.sv
// Randomized self-checking bench for sos_band_scheduler against a behavioural band/section model.
// Engine model: configurable latency and transfer function; timeout case only with SOS_SCHED_TIMEOUT_EN.
module tb_sos_band_scheduler;
  localparam int WS = 16, AS = 32, NB = 4, NS = 4, SH = 0, TO = 64;

  logic inClock = 1'b0, rst = 1'b0;
  logic signed [WS-1:0] inData = '0;
  logic inValid = 1'b0, inReady, secStart, secDone, outValid, overrun, error;
  logic clrOverrun = 1'b0;
  logic [3:0] secBand, secSection, outBand;
  logic signed [AS-1:0] secData, secResult;
  logic signed [WS-1:0] outData;

  int n_checks = 0, n_errors = 0;
  int eng_lat = 1, eng_mode = 0;
  bit withhold = 0, stray_idle = 0, stray_issue = 0, err_exp = 0;
  int pq_band[$], pq_sec[$];
  longint pq_data[$];

  sos_band_scheduler #(.WORD_SIZE(WS), .ACCUM_SIZE(AS), .NUM_BANDS(NB),
                       .NUM_SECTIONS(NS), .OUT_SHIFT(SH), .TIMEOUT(TO)) dut (
    .inClock(inClock), .rst(rst), .inData(inData), .inValid(inValid), .inReady(inReady),
    .secStart(secStart), .secBand(secBand), .secSection(secSection), .secData(secData),
    .secDone(secDone), .secResult(secResult), .outValid(outValid), .outBand(outBand),
    .outData(outData), .overrun(overrun), .clrOverrun(clrOverrun), .error(error));

  always #5 inClock = ~inClock;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge inClock);
    @(negedge inClock);
  endtask

  function automatic longint eng_f(input int mode, input longint x);
    longint r;
    logic signed [31:0] t;
    case (mode)
      0:       r = x + 1;
      1:       r = x * 2;
      default: r = 7 - x;
    endcase
    t = r[31:0];
    return longint'(t);
  endfunction

  function automatic longint sat_w(input longint v);
    longint s;
    s = v >>> SH;
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  // Engine: sees secStart in cycle c, answers with secDone in cycle c+eng_lat.
  initial begin
    int cnt = 0, cb = 0, cs = 0;
    longint cd = 0;
    secDone = 1'b0;
    secResult = '0;
    forever begin
      @(negedge inClock);
      secDone = 1'b0;
      if (!rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0 && !(withhold && cb == 1 && cs == 2)) begin
            secDone = 1'b1;
            secResult = AS'(eng_f(eng_mode, cd));
          end
        end
        if (stray_idle && inReady) begin
          secDone = 1'b1;
          secResult = 32'sh5a5a;
          stray_idle = 0;
        end
        if (secStart) begin
          cb = int'(secBand); cs = int'(secSection); cd = longint'(secData);
          pq_band.push_back(cb); pq_sec.push_back(cs); pq_data.push_back(cd);
          cnt = eng_lat;
          if (stray_issue) begin
            secDone = 1'b1;
            secResult = 32'sh1234;
            stray_issue = 0;
          end
        end
      end
    end
  end

  task automatic run_sample(input logic signed [WS-1:0] smp, input int lat, input int mode,
                            input int ovr_cyc, input int clr_cyc, input int rst_cyc,
                            input bit stray, input bit hold);
    longint exp_out[NB];
    longint exp_pd[NB*NS];
    longint acc;
    int emits = 0, ret = -1, exp_emits = NB;
    bit aborted = 0;
    eng_lat = lat; eng_mode = mode; withhold = hold;
    pq_band.delete(); pq_sec.delete(); pq_data.delete();
    for (int b = 0; b < NB; b++) begin
      acc = longint'(smp);
      for (int s = 0; s < NS; s++) begin
        exp_pd[b*NS+s] = acc;
        acc = (hold && b == 1 && s == 2) ? 0 : eng_f(mode, acc);
      end
      exp_out[b] = sat_w(acc);
    end
    if (rst_cyc > 0) begin
      exp_emits = 0;
      for (int b = 0; b < NB; b++)
        if (1 + b*(NS*(1+lat)+1) + NS*(1+lat) < rst_cyc) exp_emits++;
    end
    if (stray) begin
      stray_idle = 1;
      tick(); tick();
      stray_issue = 1;
    end
    inData = smp; inValid = 1'b1;
    tick();
    inValid = 1'b0; inData = 16'sh7777;
    for (int c = 1; c <= 400; c++) begin
      if (c == rst_cyc) begin
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
          chk("rst_ready", inReady, 1);
          chk("rst_outvalid", outValid, 0);
          chk("rst_secstart", secStart, 0);
          chk("rst_outdata", outData, 0);
          chk("rst_secdata", secData, 0);
          chk("rst_overrun", overrun, 0);
          tick();
        end
        rst = 1'b1;
        aborted = 1;
        break;
      end
      if (outValid) begin
        chk("out_band", outBand, emits);
        if (emits < NB) begin
          chk("out_data", outData, exp_out[emits]);
          if (!hold) chk("out_cycle", c, 1 + emits*(NS*(1+lat)+1) + NS*(1+lat));
        end
        emits++;
      end
      if (inReady) begin
        ret = c;
        break;
      end
      inValid = (c == ovr_cyc);
      clrOverrun = (c == clr_cyc);
      tick();
    end
    inValid = 1'b0; clrOverrun = 1'b0;
    chk("emit_count", emits, exp_emits);
    if (!aborted) begin
      if (ret < 0) chk("ready_timeout", 0, 1);
      if (!hold) chk("ready_cycle", ret, 1 + NB*(NS*(1+lat)+1));
      chk("pass_count", pq_data.size(), NB*NS);
      for (int i = 0; i < pq_data.size() && i < NB*NS; i++) begin
        chk("pass_band", pq_band[i], i / NS);
        chk("pass_sec", pq_sec[i], i % NS);
        chk("pass_data", pq_data[i], exp_pd[i]);
      end
      chk("overrun", overrun, (ovr_cyc > 0) ? 1 : 0);
      chk("error", error, err_exp);
    end
  endtask

  initial begin
    tick(); tick();
    chk("reset_ready", inReady, 1);
    chk("reset_outvalid", outValid, 0);
    chk("reset_secstart", secStart, 0);
    chk("reset_outdata", outData, 0);
    chk("reset_secdata", secData, 0);
    chk("reset_error", error, 0);
    rst = 1'b1;
    tick();
    chk("idle_ready", inReady, 1);
    chk("idle_overrun", overrun, 0);

    run_sample(100, 1, 0, 0, 0, 0, 0, 0);
    run_sample(30000, 1, 1, 0, 0, 0, 0, 0);
    run_sample(-30000, 1, 1, 0, 0, 0, 0, 0);
    run_sample(100, 1, 0, 5, 0, 0, 0, 0);
    clrOverrun = 1'b1;
    tick();
    clrOverrun = 1'b0;
    chk("overrun_clear", overrun, 0);
    run_sample(100, 1, 0, 5, 5, 0, 0, 0);
    clrOverrun = 1'b1;
    tick();
    clrOverrun = 1'b0;
    chk("overrun_clear2", overrun, 0);
    run_sample(100, 1, 0, 0, 0, 12, 0, 0);
    run_sample(-50, 1, 0, 0, 0, 0, 0, 0);
    run_sample(100, 1, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 20; i++) begin
      logic signed [WS-1:0] smp;
      smp = WS'($urandom_range(0, 65535));
      run_sample(smp, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)), 0, 0, 0, 0, 0);
    end

`ifdef SOS_SCHED_TIMEOUT_EN
    err_exp = 1;
    run_sample(100, 1, 0, 0, 0, 0, 0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sos_band_scheduler.md
# sos_band_scheduler

- Sequences one shared second-order-section (biquad) engine across several filter bands, each a cascade of sections.
- For every accepted audio sample, it issues one engine pass per section per band, in order.
- It carries the accumulator-width intermediate result from section to section and emits one saturated word-width output per band.
- It sits between the sample source and the visualizer's band-energy logic, replacing per-band hardware cascades.

## Interface
- WORD_SIZE, 16, sample/output width (signed)
- ACCUM_SIZE, 32, intermediate width (signed); must exceed WORD_SIZE
- NUM_BANDS, 4, bands per sample (1..16)
- NUM_SECTIONS, 4, sections per band (1..16)
- OUT_SHIFT, 0, arithmetic right shift applied before output saturation
- TIMEOUT, 64, engine-response watchdog limit in cycles (only with SOS_SCHED_TIMEOUT_EN)

Ports (one clock `inClock`; reset `rst` is asynchronous and active-low):
- inClock  in  1  clock
- rst  in  1  asynchronous active-low reset
- inData  in  WORD_SIZE  signed sample
- inValid  in  1  sample strobe
- inReady  out  1  high when in IDLE
- secStart  out  1  one-cycle engine start pulse
- secBand  out  4  band index for coefficient/state selection
- secSection  out  4  section index
- secData  out  ACCUM_SIZE  engine input
- secDone  in  1  engine result strobe
- secResult  in  ACCUM_SIZE  engine output
- outValid  out  1  one-cycle band result strobe
- outBand  out  4  band of outData
- outData  out  WORD_SIZE  saturated band result
- overrun  out  1  sticky: inValid seen while not ready
- clrOverrun  in  1  synchronous clear of overrun
- error  out  1  sticky engine timeout (0 when macro absent)

## Operation
- Reset values:
  - All outputs 0 except inReady=1.
  - State is IDLE; band and section counters are 0; the latched sample and the accumulator are 0.
- States and transitions:
  - **IDLE:** When inValid=1, latch inData, set acc to inData sign-extended to ACCUM_SIZE, set band=0 and sec=0, and go to ISSUE.
  - **ISSUE:** Drive secStart=1 for one cycle, with secData=acc, secBand=band, secSection=sec. Go to WAIT.
  - **WAIT:** When secDone=1, set acc to secResult. If sec=NUM_SECTIONS-1, go to EMIT; otherwise increment sec and go to ISSUE.
  - **EMIT:** Drive outValid=1, outBand=band, outData=sat(acc>>>OUT_SHIFT). If band=NUM_BANDS-1, go to IDLE. Otherwise increment band, clear sec, reload acc from the latched sample sign-extended, and go to ISSUE.
- Saturation clamps to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1].
- secBand, secSection and secData hold their values until the next ISSUE.
- outBand and outData hold their values until the next EMIT.
- secDone arriving in IDLE, ISSUE or EMIT is ignored.
- inValid while not in IDLE sets overrun; the sample is dropped.
- If clrOverrun and a new overrun event occur in the same cycle, overrun stays 1.
- Mid-operation reset aborts the sample immediately, with no outValid; the state returns to reset values.

## Timing
- inValid is captured at cycle 0; the first secStart is at cycle 1.
- Engine latency L ≥ 1 is measured from the secStart cycle to the secDone cycle. Each section occupies 1+L cycles.
- outValid for band b occurs at cycle 1 + b·(NUM_SECTIONS·(1+L)+1) + NUM_SECTIONS·(1+L).
- IDLE is re-entered one cycle after the last EMIT; inReady=1 from that cycle on.
- Defaults with L=1:
  - Band outputs at cycles 9, 18, 27 and 36.
  - inReady returns at cycle 37.

## Configuration
- **SOS_SCHED_TIMEOUT_EN defined:**
  - WAIT counts cycles without secDone.
  - On reaching TIMEOUT, the block treats the section as done with acc=0, sets the sticky error flag and continues the sequence normally.
  - error clears only on reset.
- **Not defined:**
  - WAIT waits indefinitely.
  - error is tied to 0 and the counter is not built.

## Test plan
- Normal run: engine model with result=data+1 and L=1; inData=100 → outValid at cycles 9/18/27/36, outBand 0..3, outData=104 each; inReady low from cycle 1 to cycle 36.
- Saturation: engine model with result=data·2; inData=30000 → outData=32767 for every band; inData=-30000 → outData=-32768.
- Overrun: inValid pulsed again at cycle 5 → overrun=1, outputs identical to the normal run. Then clrOverrun=1 for one cycle → overrun=0.
- Timeout (macro defined, TIMEOUT=64): engine model with result=data+1 withholds secDone for band 1 section 2 → error=1 after 64 WAIT cycles; band 1 outData=1; bands 0, 2 and 3 outData=104.
- Reset mid-sample: rst low at cycle 12 → all outputs 0 and inReady=1 while rst is low, no further outValid. A new inData=-50 after release → band outputs -46.
- Stray secDone: secDone pulsed in IDLE and in ISSUE → no state change; results as in the normal run.
